// File: rtl/bcd_to_bin_seq.sv
// Packed BCD (N_DIGIT+1 digits) to binary, one digit per clock MSD first; result after ND clocks.
// Valid/ready both sides: accepts only in IDLE, result held in DONE until out_ready.
module bcd_to_bin_seq #(
    parameter int N_DIGIT = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [N_DIGIT*4+3:0]                    bcd_in,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [$clog2(10**(N_DIGIT+1))-1:0]      bin_out,
    output logic                                    err
);

    localparam int ND    = N_DIGIT + 1;
    localparam int BIN_W = $clog2(10**ND);
    localparam int CNT_W = $clog2(ND + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ND - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ND*4-1:0]    sr_q, sr_d;
    logic [BIN_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               eout_q, eout_d;

    logic [3:0]         digit;
    logic [BIN_W-1:0]   acc_nxt;
    logic               err_nxt;

    // Invalid inputs may wrap the accumulator; the result is zeroed on error.
    assign digit   = sr_q[ND*4-1 -: 4];
    assign acc_nxt = (acc_q << 3) + (acc_q << 1) + {{(BIN_W-4){1'b0}}, digit};
    assign err_nxt = err_q | (digit > 4'd9);

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        bin_d   = bin_q;
        eout_d  = eout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d    = bcd_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d = acc_nxt;
                sr_d  = sr_q << 4;
                cnt_d = cnt_q + CNT_W'(1);
                err_d = err_nxt;
                if (cnt_q == CNT_LAST) begin
                    bin_d   = err_nxt ? '0 : acc_nxt;
                    eout_d  = err_nxt;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            bin_q   <= '0;
            eout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            bin_q   <= bin_d;
            eout_q  <= eout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bin_out   = bin_q;
    assign err       = eout_q;

endmodule
